host_bus_cmd_master: RTL and testbench

//  Initiator on the host memory interface (host_valid/host_ready/host_addr/host_wdata/host_wstrb/host_rdata),
//  i.e. the requester side the APB bridge responds to. Takes a byte-stream command channel (debug UART/SPI

---
 rtl/host_bus_cmd_master.sv | 208 ++++++++++++++++++++
 tb/tb_host_bus_cmd_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_cmd_master.sv
// Byte-stream command channel to 32-bit host bus master: one read/write per command frame.
// Optional host_ready watchdog enabled by defining HBM_TIMEOUT_EN.
module host_bus_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        host_valid,
  input  logic        host_ready,
  output logic [31:0] host_addr,
  output logic [31:0] host_wdata,
  output logic [3:0]  host_wstrb,
  input  logic [31:0] host_rdata,
  output logic        busy
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_OK   = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;
`ifdef HBM_TIMEOUT_EN
  localparam logic [7:0] RSP_TMO  = 8'hE0;
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_GET_STRB, S_GET_ADDR, S_GET_DATA, S_BUS, S_RSP_STAT, S_RSP_DATA
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } host_req_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic        is_write, is_write_next;
  host_req_t   req_q, req_next;
  logic [31:0] rdata_q, rdata_next;
  logic        rsp_valid_next, host_valid_next, cmd_ready_next, busy_next;
  logic [7:0]  rsp_data_next;
  logic        cmd_fire, rsp_fire;
`ifdef HBM_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_cnt, wait_next;
`endif

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign rsp_fire   = rsp_valid & rsp_ready;
  assign host_addr  = req_q.addr;
  assign host_wdata = req_q.wdata;
  assign host_wstrb = req_q.wstrb;

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    is_write_next   = is_write;
    req_next        = req_q;
    rdata_next      = rdata_q;
    rsp_valid_next  = rsp_valid;
    rsp_data_next   = rsp_data;
    host_valid_next = host_valid;
`ifdef HBM_TIMEOUT_EN
    wait_next       = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_data == OP_WRITE) begin
            is_write_next = 1'b1;
            state_next    = S_GET_STRB;
          end else if (cmd_data == OP_READ) begin
            is_write_next  = 1'b0;
            req_next.wstrb = 4'h0;
            state_next     = S_GET_ADDR;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = RSP_ERR;
            state_next     = S_RSP_STAT;
          end
        end
      end
      S_GET_STRB: begin
        if (cmd_fire) begin
          req_next.wstrb = cmd_data[3:0];
          state_next     = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        if (cmd_fire) begin
          req_next.addr[{cnt, 3'b000} +: 8] = cmd_data;
          req_next.addr[1:0] = 2'b00;
          cnt_next = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_write) begin
              state_next = S_GET_DATA;
            end else begin
              host_valid_next = 1'b1;
              state_next      = S_BUS;
            end
          end
        end
      end
      S_GET_DATA: begin
        if (cmd_fire) begin
          req_next.wdata[{cnt, 3'b000} +: 8] = cmd_data;
          cnt_next = cnt + 2'd1;
          // A zero strobe would look like a read on the bus, so reject it after the full frame
          if (cnt == 2'd3) begin
            if (req_q.wstrb == 4'h0) begin
              rsp_valid_next = 1'b1;
              rsp_data_next  = RSP_ERR;
              state_next     = S_RSP_STAT;
            end else begin
              host_valid_next = 1'b1;
              state_next      = S_BUS;
            end
          end
        end
      end
      S_BUS: begin
        if (host_ready) begin
          rdata_next      = host_rdata;
          host_valid_next = 1'b0;
          rsp_valid_next  = 1'b1;
          rsp_data_next   = RSP_OK;
          state_next      = S_RSP_STAT;
        end
`ifdef HBM_TIMEOUT_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          host_valid_next = 1'b0;
          rsp_valid_next  = 1'b1;
          rsp_data_next   = RSP_TMO;
          state_next      = S_RSP_STAT;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
`endif
      end
      S_RSP_STAT: begin
        if (rsp_fire) begin
          rsp_valid_next = 1'b0;
          state_next = (!is_write && rsp_data == RSP_OK) ? S_RSP_DATA : S_IDLE;
        end
      end
      S_RSP_DATA: begin
        // Each data byte is presented one cycle after the previous one was taken
        if (rsp_fire) begin
          rsp_valid_next = 1'b0;
          cnt_next       = cnt + 2'd1;
          if (cnt == 2'd3) state_next = S_IDLE;
        end else if (!rsp_valid) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = rdata_q[{cnt, 3'b000} +: 8];
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next != state) cnt_next = 2'd0;
`ifdef HBM_TIMEOUT_EN
    if (state_next == S_BUS && state != S_BUS) wait_next = '0;
`endif
    cmd_ready_next = (state_next == S_IDLE) || (state_next == S_GET_STRB) ||
                     (state_next == S_GET_ADDR) || (state_next == S_GET_DATA);
    busy_next      = (state_next != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      is_write   <= 1'b0;
      req_q      <= '0;
      rdata_q    <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      host_valid <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
`ifdef HBM_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      is_write   <= is_write_next;
      req_q      <= req_next;
      rdata_q    <= rdata_next;
      rsp_valid  <= rsp_valid_next;
      rsp_data   <= rsp_data_next;
      host_valid <= host_valid_next;
      cmd_ready  <= cmd_ready_next;
      busy       <= busy_next;
`ifdef HBM_TIMEOUT_EN
      wait_cnt   <= wait_next;
`endif
    end
  end

endmodule

// File: tb/tb_host_bus_cmd_master.sv
// Bench for host_bus_cmd_master: command-frame table plus reset, stall and watchdog sequences.
module tb_host_bus_cmd_master;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        host_valid;
  logic        host_ready = 1'b0;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_wstrb;
  logic [31:0] host_rdata = 32'h0;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  host_bus_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_rdata(host_rdata),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [7:0]  exp_status;
    bit          exp_bus;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  bus_t bus_q[$];
  logic [7:0] rsp_q[$];
  int   ready_delay = 0;
  bit   never_ready = 1'b0;
  bit   idle_pulse = 1'b0;
  int   rsp_mode = 0;
  int   hv_total = 0;
  int   resp_wait = 0;
  bit   stalled = 1'b0;
  logic [7:0] held_data = 8'h00;
  bus_t mon_b;
  logic [7:0] mon_r;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Host bus target: ready after ready_delay cycles of host_valid
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (!host_valid) begin
      resp_wait  = 0;
      host_ready = idle_pulse;
    end else begin
      host_ready = !never_ready && (resp_wait >= ready_delay);
      resp_wait++;
    end
  end

  // Response consumer: 0 always ready, 1 held off, 2 toggling, 3 one byte then held off
  initial forever begin
    @(posedge sys_clk);
    #1;
    case (rsp_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'b0;
      2: rsp_ready = ~rsp_ready;
      default: begin
        rsp_ready = 1'b1;
        rsp_mode  = 1;
      end
    endcase
  end

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (host_valid) hv_total++;
      if (host_valid && host_ready) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus_cycle", host_addr, 32'hFFFF_FFFF);
        end else begin
          mon_b = bus_q.pop_front();
          check("bus_addr", host_addr, mon_b.addr);
          check("bus_wdata", host_wdata, mon_b.wdata);
          check("bus_wstrb", 32'(host_wstrb), 32'(mon_b.wstrb));
        end
      end
      if (stalled) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'(rsp_data), 32'(held_data));
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp_byte", 32'(rsp_data), 32'h100);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_byte", 32'(rsp_data), 32'(mon_r));
        end
      end
      if (rsp_valid) check("cmd_ready_during_rsp", 32'(cmd_ready), 32'd0);
      stalled   = rsp_valid && !rsp_ready;
      held_data = rsp_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!cmd_ready && n < 2000);
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      tick(1);
    end else begin
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(op);
    check("busy_after_opcode", 32'(busy), 32'd1);
    if (op == 8'h01) send_byte(strb);
    if (op == 8'h01 || op == 8'h02)
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (op == 8'h01)
      for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic push_expect(input vec_t v);
    bus_t b;
    if (v.exp_bus) begin
      b.addr  = v.addr & 32'hFFFF_FFFC;
      b.wdata = (v.op == 8'h01) ? v.wdata : host_wdata;
      b.wstrb = (v.op == 8'h01) ? v.strb[3:0] : 4'h0;
      bus_q.push_back(b);
    end
    rsp_q.push_back(v.exp_status);
    if (v.op == 8'h02 && v.exp_status == 8'hA5)
      for (int i = 0; i < 4; i++) rsp_q.push_back(v.rdata[8*i +: 8]);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((busy || rsp_q.size() != 0) && n < bound) begin
      tick(1);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    check("rsp_all_seen", 32'(rsp_q.size()), 32'd0);
    check("bus_all_seen", 32'(bus_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    ready_delay = v.delay;
    host_rdata  = v.rdata;
    start       = hv_total;
    push_expect(v);
    send_cmd(v.op, v.strb, v.addr, v.wdata);
    check("host_valid_latency", 32'(host_valid), 32'(v.exp_bus));
    wait_done(500);
    check("host_valid_cycles", 32'(hv_total - start), v.exp_bus ? 32'(v.delay + 1) : 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_host_valid", 32'(host_valid), 32'd0);
    check("rst_host_addr", host_addr, 32'd0);
    check("rst_host_wdata", host_wdata, 32'd0);
    check("rst_host_wstrb", 32'(host_wstrb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    bus_q.delete();
    rsp_q.delete();
    rst = 1'b1;
    tick(1);
    check_reset_vals();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h0F, 32'h4000_0000, 32'hDEAD_BEEF, 32'h0,         1, 8'hA5, 1'b1};
    vecs[1] = '{8'h02, 8'h00, 32'h4000_0004, 32'h0,         32'h1234_5678, 0, 8'hA5, 1'b1};
    vecs[2] = '{8'h7F, 8'h00, 32'h0,         32'h0,         32'h0,         0, 8'hEE, 1'b0};
    vecs[3] = '{8'h01, 8'h00, 32'h4000_0010, 32'h5555_AAAA, 32'h0,         0, 8'hEE, 1'b0};
    vecs[4] = '{8'h01, 8'hF3, 32'h1000_0003, 32'h0102_0304, 32'h0,         3, 8'hA5, 1'b1};
    vecs[5] = '{8'h02, 8'h00, 32'hFFFF_FFFC, 32'h0,         32'hA5EE_00FF, 2, 8'hA5, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 32'h0,         32'h0,         32'h0,         0, 8'hEE, 1'b0};
    vecs[7] = '{8'h01, 8'h30, 32'h2000_0000, 32'h1111_2222, 32'h0,         0, 8'hEE, 1'b0};
    vecs[8] = '{8'h02, 8'h00, 32'h0000_0000, 32'h0,         32'h8000_0001, 5, 8'hA5, 1'b1};

    rst = 1'b1;
    tick(3);
    check_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // host_ready while idle must be ignored
    idle_pulse = 1'b1;
    tick(3);
    idle_pulse = 1'b0;
    tick(2);
    check("idle_pulse_busy", 32'(busy), 32'd0);
    check("idle_pulse_host_valid", 32'(host_valid), 32'd0);

    // Read with response stalled, then drained with a toggling ready
    begin
      vec_t v;
      v = '{8'h02, 8'h00, 32'h4000_0008, 32'h0, 32'hCAFE_F00D, 0, 8'hA5, 1'b1};
      rsp_mode    = 1;
      ready_delay = 0;
      host_rdata  = v.rdata;
      push_expect(v);
      send_cmd(v.op, v.strb, v.addr, v.wdata);
      tick(20);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_rsp_pending", 32'(rsp_q.size()), 32'd5);
      rsp_mode = 2;
      wait_done(200);
      rsp_mode = 0;
    end

`ifdef HBM_TIMEOUT_EN
    // Watchdog: no host_ready, host_valid held exactly 8 cycles, single 0xE0 byte
    begin
      int start;
      never_ready = 1'b1;
      start = hv_total;
      rsp_q.push_back(8'hE0);
      send_cmd(8'h02, 8'h00, 32'h4000_000C, 32'h0);
      wait_done(200);
      check("timeout_hv_cycles", 32'(hv_total - start), 32'd8);
      never_ready = 1'b0;
      run_vec(vecs[1]);
    end
`endif

    // Reset while waiting on the bus (without the watchdog: after a long wait)
    never_ready = 1'b1;
    send_cmd(8'h02, 8'h00, 32'h4000_0020, 32'h0);
`ifdef HBM_TIMEOUT_EN
    tick(3);
`else
    tick(1000);
    check("no_timeout_rsp_valid", 32'(rsp_valid), 32'd0);
`endif
    check("bus_wait_host_valid", 32'(host_valid), 32'd1);
    check("bus_wait_busy", 32'(busy), 32'd1);
    do_reset();
    never_ready = 1'b0;
    run_vec(vecs[0]);

    // Reset while presenting read data bytes
    begin
      vec_t v;
      int n;
      v = '{8'h02, 8'h00, 32'h4000_0030, 32'h0, 32'h0BAD_CAFE, 0, 8'hA5, 1'b1};
      rsp_mode   = 1;
      host_rdata = v.rdata;
      push_expect(v);
      send_cmd(v.op, v.strb, v.addr, v.wdata);
      n = 0;
      while (!rsp_valid && n < 100) begin
        tick(1);
        n++;
      end
      check("rsp_stat_presented", 32'(rsp_valid), 32'd1);
      rsp_mode = 3;
      tick(4);
      check("rsp_data_phase_left", 32'(rsp_q.size()), 32'd4);
      check("rsp_data_phase_valid", 32'(rsp_valid), 32'd1);
      do_reset();
      rsp_mode = 0;
    end
    run_vec(vecs[1]);
    run_vec(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
